// File: rtl/lc3_mem_responder.sv
// LC-3 memory-side responder: word RAM with programmable wait states, preload port and range error.
// Optional `LC3_MMIO_DISPLAY_EN` decodes DSR (xFE04) and DDR (xFE06) for a character display.
module lc3_mem_responder #(
  parameter int unsigned DEPTH_LOG2  = 12,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_err,
  input  logic        ld_en,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_data,
  output logic        disp_valid,
  output logic [7:0]  disp_char,
  output logic [1:0]  dbg_state
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  // Handshake: mem_en/we/addr/wdata are captured on the IDLE edge where mem_en=1;
  // mem_ready pulses for exactly the RESP cycle, and mem_en low during WAIT aborts.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        we_q, we_d;

  logic [15:0] ram [DEPTH];
  logic [DEPTH_LOG2-1:0] ram_idx, ld_idx;
  logic        in_range, is_dsr, is_ddr, resp, core_wr;
  logic [15:0] rd_val;
  logic        ld_addr_unused;

  assign ram_idx        = addr_q[DEPTH_LOG2-1:0];
  assign ld_idx         = ld_addr[DEPTH_LOG2-1:0];
  assign ld_addr_unused = ^(ld_addr >> DEPTH_LOG2);
  assign in_range       = (addr_q >> DEPTH_LOG2) == 16'd0;
  assign resp           = (state_q == S_RESP);

`ifdef LC3_MMIO_DISPLAY_EN
  assign is_dsr     = (addr_q == 16'hFE04);
  assign is_ddr     = (addr_q == 16'hFE06);
  assign disp_valid = resp && we_q && is_ddr;
  assign disp_char  = disp_valid ? wdata_q[7:0] : 8'h00;
`else
  assign is_dsr     = 1'b0;
  assign is_ddr     = 1'b0;
  assign disp_valid = 1'b0;
  assign disp_char  = 8'h00;
`endif

  always_comb begin
    rd_val = 16'h0000;
    if (is_dsr)
      rd_val = 16'h8000;
    else if (is_ddr)
      rd_val = 16'h0000;
    else if (in_range)
      rd_val = ram[ram_idx];
  end

  assign core_wr   = resp && we_q && in_range && !is_ddr;
  assign mem_ready = resp;
  assign mem_err   = resp && !in_range && !is_dsr && !is_ddr;
  // Read data is combinational in RESP so a same-cycle preload still returns the old word.
  assign mem_rdata = resp ? rd_val : rdata_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = resp ? rd_val : rdata_q;
    case (state_q)
      S_IDLE: begin
        if (mem_en) begin
          addr_d  = mem_addr;
          we_d    = mem_we;
          wdata_d = mem_wdata;
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!mem_en) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'h0000;
      we_q    <= 1'b0;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Core write is issued last so it wins a same-word collision with a preload.
  always_ff @(posedge clk) begin
    if (ld_en)
      ram[ld_idx] <= ld_data;
    if (core_wr)
      ram[ram_idx] <= wdata_q;
  end

endmodule
